// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers for the EX stage.
// Define MDU_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle one.
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   aRaw_q, aRaw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               negLo_q, negLo_d;
  logic               negHi_q, negHi_d;
  logic               isDiv_q, isDiv_d;
  logic               divZero_q, divZero_d;
  logic               divOvf_q, divOvf_d;
  logic               done_q, done_d;

  logic               isSigned, aNeg, bNeg;
  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH:0]     mulSum, remShift, divDiff;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;
`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fastProd;
`endif

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Operate on magnitudes; signs are re-applied once in FIX.
  assign isSigned = (op == OP_MULT) || (op == OP_DIV);
  assign aNeg     = isSigned && a[WIDTH-1];
  assign bNeg     = isSigned && b[WIDTH-1];
  assign magA     = aNeg ? -a : a;
  assign magB     = bNeg ? -b : b;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    aRaw_d    = aRaw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    negLo_d   = negLo_q;
    negHi_d   = negHi_q;
    isDiv_d   = isDiv_q;
    divZero_d = divZero_q;
    divOvf_d  = divOvf_q;
    done_d    = 1'b0;

    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
    // Restoring step: the top bit of divDiff is the borrow of the trial subtraction.
    remShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divDiff  = remShift - {1'b0, mcand_q};
    prodFix  = negLo_q ? -acc_q : acc_q;
    quoFix   = negLo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remFix   = negHi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`ifdef MDU_FAST_MUL_EN
    fastProd = {{WIDTH{1'b0}}, magA} * {{WIDTH{1'b0}}, magB};
`endif

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
              {hi_d, lo_d} = (aNeg ^ bNeg) ? -fastProd : fastProd;
              done_d       = 1'b1;
`else
              acc_d   = {{WIDTH{1'b0}}, magB};
              mcand_d = magA;
              negLo_d = aNeg ^ bNeg;
              isDiv_d = 1'b0;
              count_d = CW'(WIDTH);
              state_d = MUL;
`endif
            end
            OP_DIV, OP_DIVU: begin
              acc_d     = {{WIDTH{1'b0}}, magA};
              mcand_d   = magB;
              aRaw_d    = a;
              negLo_d   = aNeg ^ bNeg;
              negHi_d   = aNeg;
              isDiv_d   = 1'b1;
              divZero_d = (b == {WIDTH{1'b0}});
              divOvf_d  = isSigned && (a == MIN_VAL) && (b == ALL_ONES);
              count_d   = CW'(WIDTH);
              state_d   = DIV;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d   = {mulSum, acc_q[WIDTH-1:1]};
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) state_d = FIX;
        end
      end
      DIV: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (!divDiff[WIDTH]) acc_d = {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                 acc_d = {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!isDiv_q) begin
            {hi_d, lo_d} = prodFix;
          end else if (divZero_q) begin
            hi_d = aRaw_q;
            lo_d = ALL_ONES;
          end else if (divOvf_q) begin
            hi_d = {WIDTH{1'b0}};
            lo_d = MIN_VAL;
          end else begin
            hi_d = remFix;
            lo_d = quoFix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      aRaw_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      negLo_q   <= 1'b0;
      negHi_q   <= 1'b0;
      isDiv_q   <= 1'b0;
      divZero_q <= 1'b0;
      divOvf_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      aRaw_q    <= aRaw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      negLo_q   <= negLo_d;
      negHi_q   <= negHi_d;
      isDiv_q   <= isDiv_d;
      divZero_q <= divZero_d;
      divOvf_q  <= divOvf_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Testbench for mdu_hilo: directed cases then random ops checked against a 64-bit arithmetic model.
// Honours MDU_FAST_MUL_EN for multiply latency expectations.
module tb_mdu_hilo;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_BUSY = W + 1;
`endif
  localparam int DIV_BUSY = W + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          flush = 1'b0;
  logic          ready, done;
  logic [W-1:0]  hi, lo;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] modelHi = '0;
  logic [W-1:0] modelLo = '0;

  mdu_hilo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .ready(ready), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result of a MULT/MULTU/DIV/DIVU, from plain 64-bit arithmetic.
  function automatic void refModel(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
    longint sx, sy, sp, sq, sr;
    logic [63:0] up;
    sx = $signed({{32{x[W-1]}}, x});
    sy = $signed({{32{y[W-1]}}, y});
    h = '0;
    l = '0;
    case (o)
      3'd0: begin sp = sx * sy; h = sp[63:32]; l = sp[31:0]; end
      3'd1: begin up = {32'd0, x} * {32'd0, y}; h = up[63:32]; l = up[31:0]; end
      3'd2: begin
        if (y == 0) begin h = x; l = '1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin h = '0; l = 32'h8000_0000; end
        else begin sq = sx / sy; sr = sx % sy; h = sr[31:0]; l = sq[31:0]; end
      end
      3'd3: begin
        if (y == 0) begin h = x; l = '1; end
        else begin h = x % y; l = x / y; end
      end
      default: ;
    endcase
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    check32("ready_before_start", {31'd0, ready}, 32'd1);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for the unit to go idle, then checks busy length, done and HI/LO.
  task automatic checkOutput(input string tag, input int expBusy, input logic [W-1:0] eh,
                             input logic [W-1:0] el, input bit chain);
    int busy = 0;
    while (ready !== 1'b1 && busy < 200) begin
      busy++;
      @(negedge clk);
    end
    check32({tag, "_busy"}, busy, expBusy);
    check32({tag, "_done"}, {31'd0, done}, 32'd1);
    check32({tag, "_hi"}, hi, eh);
    check32({tag, "_lo"}, lo, el);
    if (!chain) begin
      @(negedge clk);
      check32({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    end
  endtask

  task automatic doOp(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input string tag, input bit chain);
    logic [W-1:0] eh, el;
    if (o >= 3'd4) begin
      if (o == 3'd4) modelHi = x;
      if (o == 3'd5) modelLo = x;
      applyStimulus(o, x, y);
      check32({tag, "_hi"}, hi, modelHi);
      check32({tag, "_lo"}, lo, modelLo);
      check32({tag, "_ready"}, {31'd0, ready}, 32'd1);
      check32({tag, "_nodone"}, {31'd0, done}, 32'd0);
    end else begin
      refModel(o, x, y, eh, el);
      applyStimulus(o, x, y);
      checkOutput(tag, (o < 3'd2) ? MUL_BUSY : DIV_BUSY, eh, el, chain);
      modelHi = eh;
      modelLo = el;
    end
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;
    int           sel;

    repeat (2) @(negedge clk);
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    check32("rst_ready", {31'd0, ready}, 32'd1);
    check32("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    doOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0);
    check32("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    check32("multu_max_lo_const", lo, 32'h0000_0001);
    doOp(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg", 0);
    check32("mult_neg_lo_const", lo, 32'hFFFF_FFEB);
    doOp(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg", 0);
    check32("div_neg_lo_const", lo, 32'hFFFF_FFFD);
    doOp(3'd3, 32'd100, 32'd7, "divu_small", 0);
    check32("divu_small_lo_const", lo, 32'd14);
    doOp(3'd3, 32'h1234_5678, 32'd0, "divu_zero", 0);
    doOp(3'd2, 32'h0000_0005, 32'd0, "div_zero", 0);
    doOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
    check32("div_ovf_lo_const", lo, 32'h8000_0000);

    doOp(3'd4, 32'hAAAA_0000, 32'd0, "mthi", 0);
    doOp(3'd5, 32'h0000_5555, 32'd0, "mtlo", 0);

    // Flush a DIVU on its tenth busy cycle.
    applyStimulus(3'd3, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check32("flush_ready", {31'd0, ready}, 32'd1);
    check32("flush_hi", hi, 32'hAAAA_0000);
    check32("flush_lo", lo, 32'h0000_5555);
    check32("flush_nodone", {31'd0, done}, 32'd0);
    @(negedge clk);
    check32("flush_nodone2", {31'd0, done}, 32'd0);
    doOp(3'd1, 32'd3, 32'd5, "multu_3x5", 0);

    // An MTLO start while busy must be dropped.
    refModel(3'd3, 32'd1000, 32'd3, modelHi, modelLo);
    applyStimulus(3'd3, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'h1; b = '0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_start", DIV_BUSY - 4, modelHi, modelLo, 0);

    // No-op codes and start+flush in IDLE leave HI/LO alone.
    doOp(3'd6, 32'h1111_1111, 32'h2, "noop6", 0);
    doOp(3'd7, 32'h2222_2222, 32'h3, "noop7", 0);
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check32("idle_flush_hi", hi, modelHi);
    check32("idle_flush_ready", {31'd0, ready}, 32'd1);

    // Asynchronous reset mid-DIV.
    applyStimulus(3'd2, 32'h7654_3210, 32'd9);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check32("async_rst_hi", hi, 32'd0);
    check32("async_rst_lo", lo, 32'd0);
    check32("async_rst_ready", {31'd0, ready}, 32'd1);
    check32("async_rst_done", {31'd0, done}, 32'd0);
    #1 rst = 1'b0;
    modelHi = '0;
    modelLo = '0;
    @(negedge clk);

    // Random ops issued back-to-back in the done cycle.
    for (int i = 0; i < 40; i++) begin
      ro  = 3'($urandom_range(0, 5));
      rx  = $urandom;
      ry  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ry = '0;
      if (sel == 1) ry = '1;
      if (sel == 2) rx = 32'h8000_0000;
      if (sel == 3) ry = 32'($urandom_range(1, 15));
      doOp(ro, rx, ry, $sformatf("rand%0d_op%0d", i, ro), (i != 39));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the EX-stage ALU. It accepts one operation per start pulse, runs multi-cycle multiply or divide, and holds `ready` low while busy so the hazard unit can stall EX. It replaces the fixed 32-bit MDU with one configurable in width, with flush/abort support and defined divide-by-zero and overflow results.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits; must be even and ≥4.
- `CW`, `$clog2(WIDTH+1)`: iteration counter width; derived, not to be overridden.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only when `ready`=1.
- `op` input 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 are no-ops.
- `a` input WIDTH: multiplicand, dividend, or MTHI/MTLO data.
- `b` input WIDTH: multiplier or divisor.
- `flush` input 1: abort the in-flight operation (EX flush/exception).
- `ready` output 1: unit idle; equals ~busy.
- `done` output 1: one-cycle pulse after a MULT/DIV result is written to HI/LO.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - `start`&&!`flush` with op MTHI/MTLO: write `a` to HI or LO at that edge; stay in IDLE; no `done`.
  - `start`&&!`flush` with op MULT/MULTU: latch |a|,|b| for signed ops (operands as-is for unsigned) and the result sign; load counter = WIDTH; go to MUL.
  - `start`&&!`flush` with op DIV/DIVU: latch operands and the quotient and remainder signs; go to DIV.
  - op 6/7: ignored.
- MUL: shift-add, one multiplier bit per cycle into a 2·WIDTH accumulator. When counter reaches 0, go to FIX.
- DIV: restoring division, one quotient bit per cycle. When counter reaches 0, go to FIX.
- FIX: one cycle. Apply sign correction, write HI/LO, pulse `done` on the following cycle, return to IDLE.
- Sign rules:
  - Signed product is two's-complement negated when the operand signs differ.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
- Divide by zero, signed or unsigned: LO = all ones, HI = `a`.
- Signed overflow (most-negative / −1): LO = most-negative, HI = 0.
- `flush` while in MUL/DIV/FIX: go to IDLE at that edge. HI/LO are unchanged and there is no `done`.
- `start` while busy: ignored; not queued.
- `start` and `flush` in the same cycle in IDLE: flush wins and nothing is accepted. This includes MTHI/MTLO.
- Reset:
  - Applies asynchronously at any time, including mid-operation.
  - Values: state=IDLE, hi=0, lo=0, `done`=0, `ready`=1, counter=0, accumulators=0.

## Timing
- Accept edge = E0.
- MUL/DIV latency:
  - `ready` is low from after E0 through E(WIDTH+1).
  - HI/LO are updated at E(WIDTH+1).
  - `ready` returns high and `done` goes high for one cycle after E(WIDTH+1).
  - Total for WIDTH=32: 33 busy cycles.
- MTHI/MTLO: HI/LO visible the cycle after E0; `ready` stays 1.
- Back-to-back: a new `start` can be accepted in the same cycle that `done`=1.
- `hi`/`lo` are register outputs; no combinational path from inputs.
- `ready` is a function of state only, not of `start`, so there is no combinational loop with the hazard unit.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle combinational WIDTH×WIDTH multiplier.
  - HI/LO are written at E0; `ready` never drops; `done` pulses the cycle after E0.
  - MUL state is unused.
- `MDU_FAST_MUL_EN` undefined: iterative multiply as described above; no `*` operator is inferred.
- Division is iterative in both builds.

## Test plan
All scenarios use WIDTH=32, macro undefined unless stated.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `ready` low for 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001, `done` pulses once.
- MULT a=0xFFFFFFFD (−3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - Repeat with `MDU_FAST_MUL_EN` defined -> same values visible 1 cycle after accept, `ready` constantly 1.
- DIV a=0xFFFFFFF9 (−7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678.
  - DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0xAAAA0000, LO=0x5555 via MTHI/MTLO; start DIVU; assert `flush` on busy cycle 10 -> `ready`=1 next cycle, HI/LO unchanged, no `done`.
  - A following MULTU 3×5 -> LO=15, HI=0.
- During busy, pulse `start` with MTLO a=0x1 -> ignored; LO reflects only the running op.
  - Assert `rst` mid-DIV -> hi=lo=0 and `ready`=1 immediately (asynchronous).
